// File: rtl/mem_dmem_access.sv
// -----------------------------------------------------------------------------
// mem_dmem_access
// MEM-stage data-memory responder. Takes the load/store held in the EX/MEM
// pipeline register, checks size/alignment, performs it as one transaction on
// a valid/ready dmem bus and stalls the pipeline until the access completes.
// Store data is lane-shifted onto the doubleword bus. Load data is shifted
// down, truncated to the access size and sign- or zero-extended.
//
// Ports
//   sys_clk, sys_rst     clock (rising edge), asynchronous active-low reset
//   mem_req_valid        MEM stage holds a memory op this cycle
//   mem_is_write         1 = store, 0 = load
//   mem_addr             byte address
//   mem_byte_mask        size mask 8'h01/03/0F/FF = B/H/W/D
//   mem_load_signed      sign-extend the load result when 1
//   mem_write_data       store data, LSB-aligned
//   mem_stall            hold IF..MEM pipeline registers
//   mem_rdata            last successful load result, aligned and extended
//   mem_done, mem_err    one-cycle completion pulse and its error flag
//   dmem_req_*           bus request channel (doubleword address, strobes)
//   dmem_rsp_*           bus response channel (read data, error)
// -----------------------------------------------------------------------------
module mem_dmem_access #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 256
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            mem_req_valid,
    input  logic            mem_is_write,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [7:0]      mem_byte_mask,
    input  logic            mem_load_signed,
    input  logic [XLEN-1:0] mem_write_data,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_done,
    output logic            mem_err,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [7:0]      dmem_req_wstrb,
    output logic [XLEN-1:0] dmem_req_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    input  logic            dmem_rsp_err
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so a
    // disabled timeout still elaborates.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Expand a byte mask into a bit mask over the full data word.
    function automatic logic [XLEN-1:0] expand_mask(input logic [7:0] mask);
        logic [XLEN-1:0] m;
        m = {XLEN{1'b0}};
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{mask[b]}};
        end
        return m;
    endfunction

    // Shift the addressed lane down to bit 0, truncate to the access size and extend.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rd,
                                                     input logic [2:0]      off,
                                                     input logic [7:0]      mask,
                                                     input logic            sgn);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = rd >> {off, 3'b000};
        case (mask)
            8'h01:   res = {{(XLEN-8){sgn & sh[7]}},   sh[7:0]};
            8'h03:   res = {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
            8'h0F:   res = {{(XLEN-32){sgn & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_off;
    logic            r_we;
    logic [7:0]      r_mask;
    logic            r_sgn;
    logic [7:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_latch;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_load_upd;
    logic            w_err_next;
    logic            w_bad_req;
    logic [2:0]      w_align;
    logic            w_mask_bad;
    logic [2:0]      w_off_in;

    assign w_off_in = mem_addr[2:0];

    // Size/alignment check: offset bits below the access size must be zero.
    always_comb begin
        w_align    = 3'b000;
        w_mask_bad = 1'b0;
        case (mem_byte_mask)
            8'h01:   w_align = 3'b000;
            8'h03:   w_align = 3'b001;
            8'h0F:   w_align = 3'b011;
            8'hFF:   w_align = 3'b111;
            default: w_mask_bad = 1'b1;
        endcase
        w_bad_req = w_mask_bad | (|(w_off_in & w_align));
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and datapath control strobes.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_load_upd   = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    w_latch = 1'b1;
                    if (w_bad_req) begin
                        w_state_next = ST_DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    w_state_next = ST_RSP;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_RSP: begin
                if (dmem_rsp_valid) begin
                    w_state_next = ST_DONE;
                    w_err_next   = dmem_rsp_err;
                    w_load_upd   = ~r_we & ~dmem_rsp_err;
                end else begin
                    w_cnt_inc = 1'b1;
                    if ((TIMEOUT != 0) && (r_cnt == TMO_LAST)) begin
                        w_state_next = ST_DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = ST_RSP;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, timeout counter, load result and error flag.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_addr  <= {XLEN{1'b0}};
            r_off   <= 3'b000;
            r_we    <= 1'b0;
            r_mask  <= 8'h00;
            r_sgn   <= 1'b0;
            r_wstrb <= 8'h00;
            r_wdata <= {XLEN{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_rdata <= {XLEN{1'b0}};
            r_err   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr <= {mem_addr[XLEN-1:3], 3'b000};
                r_off  <= w_off_in;
                r_we   <= mem_is_write;
                r_mask <= mem_byte_mask;
                r_sgn  <= mem_load_signed;
                // Loads carry no strobes or data; store data is trimmed to
                // the access size before shifting so stale upper bits never
                // reach neighbouring lanes.
                if (mem_is_write) begin
                    r_wstrb <= mem_byte_mask << w_off_in;
                    r_wdata <= (mem_write_data & expand_mask(mem_byte_mask)) << {w_off_in, 3'b000};
                end else begin
                    r_wstrb <= 8'h00;
                    r_wdata <= {XLEN{1'b0}};
                end
            end
            if (w_cnt_clr) begin
                r_cnt <= {CW{1'b0}};
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_load_upd) begin
                r_rdata <= load_extract(dmem_rsp_rdata, r_off, r_mask, r_sgn);
            end
            r_err <= w_err_next;
        end
    end

    // Stall is gated by reset so every output reads 0 while reset is held.
    assign mem_stall      = sys_rst & (((r_state == ST_IDLE) & mem_req_valid) |
                                       (r_state == ST_REQ) | (r_state == ST_RSP));
    assign mem_done       = (r_state == ST_DONE);
    assign mem_err        = r_err;
    assign mem_rdata      = r_rdata;
    assign dmem_req_valid = (r_state == ST_REQ);
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = r_addr;
    assign dmem_req_wstrb = r_wstrb;
    assign dmem_req_wdata = r_wdata;

endmodule
